// File: rtl/bp_update_queue.sv
// bp_update_queue: in-order branch tracking queue. Dispatched conditional
// branches are recorded with their predicted direction. The branch ALU fills
// in the resolved outcome. On retirement the head entry drives the predictor
// update port, and a misprediction raises a redirect and a full flush.
// Optional feature macro: BQ_STATS_EN adds committed-branch and mispredict
// counters as 32-bit outputs.
module bp_update_queue #(
  parameter int DEPTH        = 8,
  parameter int AddressWidth = 32
) (
  input  logic                       clk_in,
  input  logic                       rstn_in,
  input  logic                       rdy_in,
`ifdef BQ_STATS_EN
  output logic [31:0]                bq_stat_branches_out,
  output logic [31:0]                bq_stat_mispredicts_out,
`endif
  input  logic                       dispatcher_bq_en_in,
  input  logic [AddressWidth-1:0]    dispatcher_bq_pc_in,
  input  logic                       dispatcher_bq_taken_in,
  output logic [$clog2(DEPTH)-1:0]   bq_dispatcher_tag_out,
  output logic                       bq_dispatcher_full_out,
  input  logic                       alu_bq_en_in,
  input  logic [$clog2(DEPTH)-1:0]   alu_bq_tag_in,
  input  logic                       alu_bq_taken_in,
  input  logic [AddressWidth-1:0]    alu_bq_target_in,
  output logic                       bq_rob_ready_out,
  input  logic                       rob_bq_commit_in,
  output logic                       bq_bp_en_out,
  output logic                       bq_bp_correct_out,
  output logic [AddressWidth-1:0]    bq_bp_pc_out,
  output logic                       bq_flush_out,
  output logic [AddressWidth-1:0]    bq_if_pc_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshakes: an allocate transfers on a rising edge where
  // dispatcher_bq_en_in is high and the queue is not full (or the head pops
  // in the same cycle); a retirement transfers where rob_bq_commit_in and
  // bq_rob_ready_out are both high. Nothing transfers while rdy_in is low.

  logic [DEPTH-1:0]        valid_q;
  logic [DEPTH-1:0]        resolved_q;
  logic [DEPTH-1:0]        pred_q;
  logic [DEPTH-1:0]        act_q;
  logic [AddressWidth-1:0] pc_q     [DEPTH];
  logic [AddressWidth-1:0] target_q [DEPTH];
  logic [PTR_W-1:0]        head_q;
  logic [PTR_W-1:0]        tail_q;
  logic [CNT_W-1:0]        count_q;

  logic full;
  logic head_ready;
  logic head_correct;
  logic commit_fire;
  logic mispredict;
  logic alloc_fire;
  logic resolve_fire;
  logic [AddressWidth-1:0] redirect_pc;

  // Status and transfer qualifiers, all derived from registered state.
  always_comb begin
    full         = (count_q == CNT_W'(DEPTH));
    head_ready   = valid_q[head_q] & resolved_q[head_q];
    head_correct = (pred_q[head_q] == act_q[head_q]);
    commit_fire  = rdy_in & rob_bq_commit_in & head_ready;
    mispredict   = commit_fire & ~head_correct;
    // A pop in the same cycle frees a slot; a mispredict discards the allocate.
    alloc_fire   = rdy_in & dispatcher_bq_en_in & (~full | commit_fire) & ~mispredict;
    resolve_fire = rdy_in & alu_bq_en_in & valid_q[alu_bq_tag_in];
    redirect_pc  = act_q[head_q] ? target_q[head_q]
                                 : pc_q[head_q] + AddressWidth'(4);
  end

  assign bq_dispatcher_tag_out  = tail_q;
  assign bq_dispatcher_full_out = full;
  assign bq_rob_ready_out       = head_ready;

  // Control state: pointers, occupancy, valid/resolved flags and the
  // registered update/flush outputs.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      valid_q           <= '0;
      resolved_q        <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      bq_bp_en_out      <= 1'b0;
      bq_bp_correct_out <= 1'b0;
      bq_bp_pc_out      <= '0;
      bq_flush_out      <= 1'b0;
      bq_if_pc_out      <= '0;
    end else begin
      bq_bp_en_out      <= commit_fire;
      bq_bp_correct_out <= commit_fire & head_correct;
      bq_flush_out      <= mispredict;
      if (commit_fire) bq_bp_pc_out <= pc_q[head_q];
      if (mispredict)  bq_if_pc_out <= redirect_pc;
      if (mispredict) begin
        valid_q <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (resolve_fire) resolved_q[alu_bq_tag_in] <= 1'b1;
        if (commit_fire) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        // Allocation comes last so it wins when it reuses the popped slot.
        if (alloc_fire) begin
          valid_q[tail_q]    <= 1'b1;
          resolved_q[tail_q] <= 1'b0;
          tail_q             <= tail_q + 1'b1;
        end
        count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
      end
    end
  end

  // Entry payload; validity is tracked separately, so no reset is needed.
  always_ff @(posedge clk_in) begin
    if (alloc_fire) begin
      pc_q[tail_q]   <= dispatcher_bq_pc_in;
      pred_q[tail_q] <= dispatcher_bq_taken_in;
    end
    if (resolve_fire) begin
      act_q[alu_bq_tag_in]    <= alu_bq_taken_in;
      target_q[alu_bq_tag_in] <= alu_bq_target_in;
    end
  end

`ifdef BQ_STATS_EN
  // Retirement statistics, wrapping at 2^32.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      bq_stat_branches_out    <= '0;
      bq_stat_mispredicts_out <= '0;
    end else begin
      if (commit_fire) bq_stat_branches_out    <= bq_stat_branches_out + 32'd1;
      if (mispredict)  bq_stat_mispredicts_out <= bq_stat_mispredicts_out + 32'd1;
    end
  end
`endif

endmodule
